idex_fwd_stage: RTL and testbench

- ID/EX pipeline register plus forwarding/hazard control for the 5-stage MIPS core.
- Registers the decoded instruction and register-file operands into the ID/EX stage.
- Produces the registered 2-bit forwarding selects (fa, fb) consumed by the EX-stage ALU input muxes.
- Detects load-use hazards, stalls IF/ID for one cycle and injects a bubble; counts stall cycles for performance monitoring.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/fwd_dest_decode.sv | 51 +++++
 rtl/idex_fwd_stage.sv | 145 ++++++++++++++
 tb/tb_idex_fwd_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the 5-stage MIPS pipeline.
// Opcodes, forward-select codes and the ID/EX hazard FSM states.
package mips_pkg;

  localparam logic [5:0] OP_ALU  = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Nearer producer wins: ID/EX result beats the older EX/MEM one.
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] src,
    input logic       ex_vld,
    input logic [4:0] ex_dst,
    input logic       mem_vld,
    input logic [4:0] mem_dst
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (used && ex_vld && src == ex_dst)
      sel = FWD_EXMEM;
    else if (used && mem_vld && src == mem_dst)
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/fwd_dest_decode.sv
// Decodes an instruction into its destination register
// and which of rs/rt it reads.
module fwd_dest_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [4:0]  dest_o,
  output logic        dest_vld_o,
  output logic        rs_used_o,
  output logic        rt_used_o
);

  logic [5:0] op;
  logic       unused_lo;

  assign op        = ir_i[31:26];
  assign unused_lo = ^ir_i[10:0];

  always_comb begin
    dest_o    = 5'd0;
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    unique case (1'b1)
      op == OP_ALU: begin
        dest_o    = ir_i[15:11];
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
      end
      op == OP_LW: begin
        dest_o    = ir_i[20:16];
        rs_used_o = 1'b1;
      end
      op == OP_SW: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
      end
      op == OP_ADDI: begin
        dest_o    = ir_i[20:16];
        rs_used_o = 1'b1;
      end
      op == OP_JAL: begin
        dest_o = 5'd31;
      end
      default: begin
      end
    endcase
  end

  assign dest_vld_o = dest_o != 5'd0;

endmodule

// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register with forwarding selects,
// load-use stall/bubble control and a stall-cycle counter.
module idex_fwd_stage
  import mips_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic            flush,
  input  logic [DW-1:0]   ifid_ir,
  input  logic [DW-1:0]   rf_a,
  input  logic [DW-1:0]   rf_b,
  input  logic [DW-1:0]   exmem_ir,
  output logic [DW-1:0]   idex_ir,
  output logic [DW-1:0]   idex_a,
  output logic [DW-1:0]   idex_b,
  output logic [1:0]      fa,
  output logic [1:0]      fb,
  output logic            stall,
  output logic [CNTW-1:0] stall_cnt
);

  logic [4:0] id_dest, ex_dest, mem_dest;
  logic       id_dv, ex_dv, mem_dv;
  logic       id_rs_u, id_rt_u;
  logic       unused_ex_rs, unused_ex_rt;
  logic       unused_mem_rs, unused_mem_rt;
  logic [4:0] id_rs, id_rt;
  logic       hazard;
  logic [1:0] fa_n, fb_n;

  state_e          state_q, state_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [1:0]      fa_q, fa_d;
  logic [1:0]      fb_q, fb_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  fwd_dest_decode u_id (
    .ir_i       (ifid_ir[31:0]),
    .dest_o     (id_dest),
    .dest_vld_o (id_dv),
    .rs_used_o  (id_rs_u),
    .rt_used_o  (id_rt_u)
  );

  fwd_dest_decode u_ex (
    .ir_i       (ir_q[31:0]),
    .dest_o     (ex_dest),
    .dest_vld_o (ex_dv),
    .rs_used_o  (unused_ex_rs),
    .rt_used_o  (unused_ex_rt)
  );

  fwd_dest_decode u_mem (
    .ir_i       (exmem_ir[31:0]),
    .dest_o     (mem_dest),
    .dest_vld_o (mem_dv),
    .rs_used_o  (unused_mem_rs),
    .rt_used_o  (unused_mem_rt)
  );

  assign id_rs = ifid_ir[25:21];
  assign id_rt = ifid_ir[20:16];

  // For a LW, the decoded destination is rt and is already nonzero-qualified.
  assign hazard = ir_q[31:26] == OP_LW && ex_dv &&
                  ((id_rs_u && id_rs == ex_dest) ||
                   (id_rt_u && id_rt == ex_dest));

  assign fa_n = fwd_sel(id_rs_u, id_rs, ex_dv, ex_dest,
                        mem_dv, mem_dest);
  assign fb_n = fwd_sel(id_rt_u, id_rt, ex_dv, ex_dest,
                        mem_dv, mem_dest);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (!freeze) begin
      if (flush) begin
        state_d = RUN;
        ir_d    = DW'(NOP);
        a_d     = '0;
        b_d     = '0;
        fa_d    = FWD_REG;
        fb_d    = FWD_REG;
      end else if (state_q == RUN && hazard) begin
        stall   = 1'b1;
        state_d = STALL;
        ir_d    = DW'(NOP);
        a_d     = '0;
        b_d     = '0;
        fa_d    = FWD_REG;
        fb_d    = FWD_REG;
        if (cnt_q != '1)
          cnt_d = cnt_q + CNTW'(1);
      end else begin
        state_d = RUN;
        ir_d    = ifid_ir;
        a_d     = rf_a;
        b_d     = rf_b;
        fa_d    = fa_n;
        fb_d    = fb_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= FWD_REG;
      fb_q    <= FWD_REG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idex_ir   = ir_q;
  assign idex_a    = a_q;
  assign idex_b    = b_q;
  assign fa        = fa_q;
  assign fb        = fb_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Directed bench for idex_fwd_stage: vector table plus
// hand-written saturation and reset-in-stall sequences.
module tb_idex_fwd_stage;

  function automatic logic [31:0] rr(input int rs, rt, rd,
                                     input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op,
                                     input int rs, rt, imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  localparam logic [31:0] A1 = rr(1, 2, 3, 6'h20);
  localparam logic [31:0] A2 = rr(3, 5, 4, 6'h20);
  localparam logic [31:0] I1 = ii(6'b001000, 7, 6, 1);
  localparam logic [31:0] S1 = rr(9, 3, 8, 6'h22);
  localparam logic [31:0] L1 = ii(6'b100011, 1, 2, 0);
  localparam logic [31:0] A3 = rr(2, 2, 4, 6'h20);
  localparam logic [31:0] Z1 = rr(1, 2, 0, 6'h20);
  localparam logic [31:0] Z2 = rr(0, 0, 4, 6'h20);
  localparam logic [31:0] L0 = ii(6'b100011, 1, 0, 0);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush;
  logic [31:0] ifid_ir, rf_a, rf_b, exmem_ir;

  logic [31:0] idex_ir, idex_a, idex_b;
  logic [1:0]  fa, fb;
  logic        stall;
  logic [15:0] stall_cnt;

  logic [31:0] s_ir, s_a, s_b;
  logic [1:0]  s_fa, s_fb;
  logic        s_stall;
  logic [1:0]  s_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] cur_ir, old_ir;

  always #5 clk = ~clk;

  idex_fwd_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (freeze),
    .flush     (flush),
    .ifid_ir   (ifid_ir),
    .rf_a      (rf_a),
    .rf_b      (rf_b),
    .exmem_ir  (exmem_ir),
    .idex_ir   (idex_ir),
    .idex_a    (idex_a),
    .idex_b    (idex_b),
    .fa        (fa),
    .fb        (fb),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  idex_fwd_stage #(.CNTW(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (freeze),
    .flush     (flush),
    .ifid_ir   (ifid_ir),
    .rf_a      (rf_a),
    .rf_b      (rf_b),
    .exmem_ir  (exmem_ir),
    .idex_ir   (s_ir),
    .idex_a    (s_a),
    .idex_b    (s_b),
    .fa        (s_fa),
    .fb        (s_fb),
    .stall     (s_stall),
    .stall_cnt (s_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        fz;
    logic        fl;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic        e_st;
    logic [31:0] e_ir;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [1:0]  e_fa;
    logic [1:0]  e_fb;
    int          e_cnt;
  } vec_t;

  vec_t vec [22];

  // Called at posedge+1; exmem_ir mirrors the pipeline the bench tracks.
  task automatic step(input vec_t v, input string tag);
    freeze   = v.fz;
    flush    = v.fl;
    ifid_ir  = v.ir;
    rf_a     = v.a;
    rf_b     = v.b;
    exmem_ir = old_ir;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(v.e_st));
    @(posedge clk);
    #1;
    chk({tag, ".ir"}, idex_ir, v.e_ir);
    chk({tag, ".a"}, idex_a, v.e_a);
    chk({tag, ".b"}, idex_b, v.e_b);
    chk({tag, ".fa"}, 32'(fa), 32'(v.e_fa));
    chk({tag, ".fb"}, 32'(fb), 32'(v.e_fb));
    chk({tag, ".cnt"}, 32'(stall_cnt), 32'(v.e_cnt));
    if (!v.fz) begin
      old_ir = cur_ir;
      cur_ir = v.e_ir;
    end
  endtask

  initial begin
    vec[0]  = '{0,0,A1,32'h11,32'h22, 0,A1,32'h11,32'h22,2'b00,2'b00,0};
    vec[1]  = '{0,0,A2,32'h33,32'h55, 0,A2,32'h33,32'h55,2'b10,2'b00,0};
    vec[2]  = '{0,0,A1,32'h11,32'h22, 0,A1,32'h11,32'h22,2'b00,2'b00,0};
    vec[3]  = '{0,0,I1,32'h77,32'h66, 0,I1,32'h77,32'h66,2'b00,2'b00,0};
    vec[4]  = '{0,0,S1,32'h99,32'h33, 0,S1,32'h99,32'h33,2'b00,2'b01,0};
    vec[5]  = '{0,0,L1,32'h100,32'h200, 0,L1,32'h100,32'h200,2'b00,2'b00,0};
    vec[6]  = '{0,0,A3,32'ha,32'hb, 1,32'h0,32'h0,32'h0,2'b00,2'b00,1};
    vec[7]  = '{0,0,A3,32'ha,32'hb, 0,A3,32'ha,32'hb,2'b01,2'b01,1};
    vec[8]  = '{0,0,Z1,32'h1,32'h2, 0,Z1,32'h1,32'h2,2'b00,2'b00,1};
    vec[9]  = '{0,0,Z2,32'h0,32'h0, 0,Z2,32'h0,32'h0,2'b00,2'b00,1};
    vec[10] = '{0,0,L0,32'h1,32'h0, 0,L0,32'h1,32'h0,2'b00,2'b00,1};
    vec[11] = '{0,0,Z2,32'h0,32'h0, 0,Z2,32'h0,32'h0,2'b00,2'b00,1};
    vec[12] = '{0,0,L1,32'h100,32'h200, 0,L1,32'h100,32'h200,2'b00,2'b00,1};
    vec[13] = '{0,1,A3,32'ha,32'hb, 0,32'h0,32'h0,32'h0,2'b00,2'b00,1};
    vec[14] = '{0,0,A3,32'hc,32'hd, 0,A3,32'hc,32'hd,2'b01,2'b01,1};
    vec[15] = '{1,1,L1,32'h5,32'h6, 0,A3,32'hc,32'hd,2'b01,2'b01,1};
    vec[16] = '{1,1,L1,32'h5,32'h6, 0,A3,32'hc,32'hd,2'b01,2'b01,1};
    vec[17] = '{1,1,L1,32'h5,32'h6, 0,A3,32'hc,32'hd,2'b01,2'b01,1};
    vec[18] = '{0,0,L1,32'h100,32'h200, 0,L1,32'h100,32'h200,2'b00,2'b00,1};
    vec[19] = '{1,0,A3,32'ha,32'hb, 0,L1,32'h100,32'h200,2'b00,2'b00,1};
    vec[20] = '{0,0,A3,32'ha,32'hb, 1,32'h0,32'h0,32'h0,2'b00,2'b00,2};
    vec[21] = '{0,0,A3,32'ha,32'hb, 0,A3,32'ha,32'hb,2'b01,2'b01,2};

    rst_n    = 1'b0;
    freeze   = 1'b0;
    flush    = 1'b0;
    ifid_ir  = '0;
    rf_a     = '0;
    rf_b     = '0;
    exmem_ir = '0;
    cur_ir   = '0;
    old_ir   = '0;
    #3;
    chk("rst.ir", idex_ir, 32'h0);
    chk("rst.a", idex_a, 32'h0);
    chk("rst.b", idex_b, 32'h0);
    chk("rst.fa", 32'(fa), 32'h0);
    chk("rst.fb", 32'(fb), 32'h0);
    chk("rst.cnt", 32'(stall_cnt), 32'h0);
    chk("rst.stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++)
      step(vec[i], $sformatf("v%0d", i));
    chk("sat.cnt2", 32'(s_cnt), 32'd2);

    for (int k = 0; k < 3; k++) begin
      step('{0,0,L1,32'h100,32'h200,
             0,L1,32'h100,32'h200,2'b00,2'b00,2+k}, "satL");
      step('{0,0,A3,32'ha,32'hb,
             1,32'h0,32'h0,32'h0,2'b00,2'b00,3+k}, "satH");
      step('{0,0,A3,32'ha,32'hb,
             0,A3,32'ha,32'hb,2'b01,2'b01,3+k}, "satS");
      chk("sat.cnt", 32'(s_cnt), 32'd3);
    end
    chk("sat.main", 32'(stall_cnt), 32'd5);

    step('{0,0,L1,32'h100,32'h200,
           0,L1,32'h100,32'h200,2'b00,2'b00,5}, "rsL");
    step('{0,0,A3,32'ha,32'hb,
           1,32'h0,32'h0,32'h0,2'b00,2'b00,6}, "rsH");
    exmem_ir = L1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs.ir", idex_ir, 32'h0);
    chk("rs.fa", 32'(fa), 32'h0);
    chk("rs.fb", 32'(fb), 32'h0);
    chk("rs.cnt", 32'(stall_cnt), 32'h0);
    chk("rs.scnt", 32'(s_cnt), 32'h0);
    chk("rs.stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cur_ir = '0;
    old_ir = '0;
    step('{0,0,A1,32'h11,32'h22,
           0,A1,32'h11,32'h22,2'b00,2'b00,0}, "post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
